// File: rtl/calc_pkg.sv
// calc_pkg: operation encodings and FSM states shared by the calculator
// arithmetic unit and its helpers.
package calc_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_DIV  = 2'b10,
      ST_DONE = 2'b11
   } state_t;

endpackage

// File: rtl/calc_addsub_w.sv
// calc_addsub_w: combinational WIDTH-bit adder/subtractor.
// Subtraction is done as a + ~b + 1, so carry_o = 1 means "no borrow".
module calc_addsub_w #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             sub_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             carry_o
);

   assign {carry_o, sum_o} = {1'b0, a_i}
                           + {1'b0, (b_i ^ {WIDTH{sub_i}})}
                           + {{WIDTH{1'b0}}, sub_i};

endmodule

// File: rtl/calc_arith_unit.sv
// calc_arith_unit: sequential unsigned arithmetic unit for the calculator.
// Add/sub finish in one cycle, multiply is shift-add and divide is restoring
// division, each taking WIDTH iterations. A memory register can capture the
// low result and feed it back as operand A.
module calc_arith_unit
   import calc_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic             use_mem,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mem_store,
   input  logic             mem_clear,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic             carry,
   output logic             div_zero,
   output logic [WIDTH-1:0] mem_q
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t           state_q;
   logic [CNT_W-1:0] count_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] resLo_q;
   logic [WIDTH-1:0] resHi_q;
   logic             carry_q;
   logic             divZero_q;
   logic [WIDTH-1:0] memReg_q;

   // Working registers: workHi_q is the product upper half / remainder,
   // workLo_q the multiplier-then-product-low / dividend-then-quotient,
   // operand_q the multiplicand or divisor.
   logic [WIDTH-1:0] workHi_q;
   logic [WIDTH-1:0] workLo_q;
   logic [WIDTH-1:0] operand_q;

   logic [WIDTH-1:0] opA;
   logic [WIDTH-1:0] addSum;
   logic             addCarry;

   logic [WIDTH-1:0] mulAddend;
   logic [WIDTH:0]   mulSum;
   logic [WIDTH-1:0] mulHi_d;
   logic [WIDTH-1:0] mulLo_d;

   logic [WIDTH-1:0] divShift;
   logic [WIDTH-1:0] trialSum;
   logic             trialCarry;
   logic             divFits;
   logic [WIDTH-1:0] divRem_d;
   logic [WIDTH-1:0] divQuo_d;

   assign opA = use_mem ? memReg_q : a;

   calc_addsub_w #(.WIDTH(WIDTH)) uAddSub (
      .a_i     (opA),
      .b_i     (b),
      .sub_i   (op == OP_SUB),
      .sum_o   (addSum),
      .carry_o (addCarry)
   );

   // One shift-add step: the accumulator sum keeps its carry as bit WIDTH,
   // which becomes the top bit after the right shift.
   assign mulAddend = workLo_q[0] ? operand_q : '0;
   assign mulSum    = {1'b0, workHi_q} + {1'b0, mulAddend};
   assign mulHi_d   = mulSum[WIDTH:1];
   assign mulLo_d   = {mulSum[0], workLo_q[WIDTH-1:1]};

   // One restoring-division step. The shifted remainder is WIDTH+1 bits; if
   // its top bit is set it certainly exceeds the divisor, and the true
   // difference then still fits in WIDTH bits, so a WIDTH-bit subtractor is
   // enough.
   assign divShift = {workHi_q[WIDTH-2:0], workLo_q[WIDTH-1]};

   calc_addsub_w #(.WIDTH(WIDTH)) uDivTrial (
      .a_i     (divShift),
      .b_i     (operand_q),
      .sub_i   (1'b1),
      .sum_o   (trialSum),
      .carry_o (trialCarry)
   );

   assign divFits  = workHi_q[WIDTH-1] | trialCarry;
   assign divRem_d = divFits ? trialSum : divShift;
   assign divQuo_d = {workLo_q[WIDTH-2:0], divFits};

   // Control FSM with all result/status outputs registered alongside it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         count_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         resLo_q   <= '0;
         resHi_q   <= '0;
         carry_q   <= 1'b0;
         divZero_q <= 1'b0;
         workHi_q  <= '0;
         workLo_q  <= '0;
         operand_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  busy_q    <= 1'b1;
                  divZero_q <= 1'b0;
                  count_q   <= '0;
                  case (op)
                     OP_ADD, OP_SUB: begin
                        resLo_q <= addSum;
                        resHi_q <= '0;
                        carry_q <= addCarry;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                     end
                     OP_MUL: begin
                        workHi_q  <= '0;
                        workLo_q  <= b;
                        operand_q <= opA;
                        state_q   <= ST_MUL;
                     end
                     default: begin
                        if (b == '0) begin
                           resLo_q   <= '1;
                           resHi_q   <= opA;
                           carry_q   <= 1'b0;
                           divZero_q <= 1'b1;
                           done_q    <= 1'b1;
                           state_q   <= ST_DONE;
                        end else begin
                           workHi_q  <= '0;
                           workLo_q  <= opA;
                           operand_q <= b;
                           state_q   <= ST_DIV;
                        end
                     end
                  endcase
               end
            end
            ST_MUL: begin
               workHi_q <= mulHi_d;
               workLo_q <= mulLo_d;
               count_q  <= count_q + 1'b1;
               if (count_q == LAST_CNT) begin
                  resLo_q <= mulLo_d;
                  resHi_q <= mulHi_d;
                  carry_q <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end
            end
            ST_DIV: begin
               workHi_q <= divRem_d;
               workLo_q <= divQuo_d;
               count_q  <= count_q + 1'b1;
               if (count_q == LAST_CNT) begin
                  resLo_q <= divQuo_d;
                  resHi_q <= divRem_d;
                  carry_q <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Memory register: clear wins over store, and it runs regardless of FSM state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         memReg_q <= '0;
      end else if (mem_clear) begin
         memReg_q <= '0;
      end else if (mem_store) begin
         memReg_q <= resLo_q;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign result_lo = resLo_q;
   assign result_hi = resHi_q;
   assign carry     = carry_q;
   assign div_zero  = divZero_q;
   assign mem_q     = memReg_q;

endmodule
